seq_mult_signed: RTL

//   Parametrised sequential shift-add multiplier; successor to the 16-bit unsigned unit.

---
 rtl/seq_mult_signed_if.sv | 39 +++
 rtl/seq_mult_signed.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/seq_mult_signed_if.sv
// Operand/result bundle between a datapath controller and the sequential multiplier.
// Latency: n/a (wiring only).
// Backpressure: none; the controller must hold off new starts until busy drops.
interface seq_mult_signed_if #(
  parameter int WIDTH = 16
);
  // Request side: sampled by the multiplier only while it is not busy.
  logic               start;
  logic               signed_mode;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;

  // Status/result side: all registered inside the multiplier.
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] res;

  // Controller view: issues operations, observes status and product.
  modport master (
    output start,
    output signed_mode,
    output a,
    output b,
    input  busy,
    input  done,
    input  res
  );

  // Multiplier view: consumes operations, drives status and product.
  modport slave (
    input  start,
    input  signed_mode,
    input  a,
    input  b,
    output busy,
    output done,
    output res
  );
endinterface

// File: rtl/seq_mult_signed.sv
// Sequential shift-add multiplier, signed or unsigned per operation, sign applied at the end.
// Latency: start edge + N RUN cycles (1..WIDTH) + done cycle; N shrinks with EARLY_EXIT.
// Backpressure: start is ignored while busy; a start in the done cycle chains back-to-back.
module seq_mult_signed #(
  parameter int WIDTH      = 16,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  seq_mult_signed_if.slave  bus
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [WIDTH-1:0] ONE_W   = WIDTH'(1);
  localparam logic [PW-1:0]    ONE_P   = PW'(1);
  localparam logic [CW-1:0]    ONE_C   = CW'(1);
  localparam logic [CW-1:0]    LAST_CN = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t            state;

  // Datapath registers. The core always multiplies magnitudes; the sign is
  // reapplied once on the final edge so the loop itself stays unsigned.
  logic [PW-1:0]     acc;
  logic [PW-1:0]     mcand;
  logic [WIDTH-1:0]  mplier;
  logic              neg;
  logic [CW-1:0]     cnt;

  // Registered outputs, decoded from the next state so they line up with it.
  logic              busy_q;
  logic              done_q;
  logic [PW-1:0]     res_q;

  // Magnitudes of the incoming operands. The most negative value maps to
  // 2^(WIDTH-1), which still fits as an unsigned WIDTH-bit number.
  logic [WIDTH-1:0]  abs_a;
  logic [WIDTH-1:0]  abs_b;
  logic              neg_in;

  // Accumulator value after this RUN cycle's conditional add, and the
  // decision whether this RUN cycle is the last one.
  logic [PW-1:0]     acc_sum;
  logic [WIDTH-1:0]  mplier_rest;
  logic              last_cycle;

  // Operand conditioning for a new request.
  always_comb begin
    abs_a  = bus.a;
    abs_b  = bus.b;
    neg_in = 1'b0;
    if (bus.signed_mode) begin
      if (bus.a[WIDTH-1]) begin
        abs_a = ~bus.a + ONE_W;
      end
      if (bus.b[WIDTH-1]) begin
        abs_b = ~bus.b + ONE_W;
      end
      neg_in = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
    end
  end

  // One shift-add step plus the RUN exit test. Once the multiplier bits still
  // to be consumed are all zero, further cycles cannot change the sum.
  always_comb begin
    acc_sum     = acc;
    mplier_rest = mplier >> 1;
    last_cycle  = 1'b0;
    if (mplier[0]) begin
      acc_sum = acc + mcand;
    end
    if (cnt == LAST_CN) begin
      last_cycle = 1'b1;
    end
    if (EARLY_EXIT && (mplier_rest == '0)) begin
      last_cycle = 1'b1;
    end
  end

  // Control FSM and datapath; busy/done are registered decodes of the next state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      neg    <= 1'b0;
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      res_q  <= '0;
    end else begin
      case (state)
        RUN: begin
          acc    <= acc_sum;
          mcand  <= mcand << 1;
          mplier <= mplier_rest;
          cnt    <= cnt + ONE_C;
          if (last_cycle) begin
            state  <= FIN;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            res_q  <= neg ? (~acc_sum + ONE_P) : acc_sum;
          end
        end

        // IDLE and FIN behave the same: a start launches a new operation,
        // otherwise settle in IDLE. res_q is left untouched here so the
        // previous product stays visible through the next RUN.
        default: begin
          if (bus.start) begin
            state  <= RUN;
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, abs_a};
            mplier <= abs_b;
            neg    <= neg_in;
            cnt    <= '0;
            busy_q <= 1'b1;
            done_q <= 1'b0;
          end else begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.res  = res_q;

endmodule
